// File: rtl/aes_key_sched_ctrl_if.sv
// Signal bundle between the AES key-schedule controller, its key generator and the key-store reader.
// The controller connects as the slave; the environment driving it connects as the master.
interface aes_key_sched_ctrl_if;
    logic         i_key_load;
    logic [127:0] i_key;
    logic         o_busy;
    logic         o_done;
    logic         o_keys_valid;
    logic [127:0] o_pre_rnd_key;
    logic         o_en_key_gen;
    logic [3:0]   o_round_num;
    logic [127:0] i_next_rnd_key;
    logic [3:0]   i_rd_round;
    logic [127:0] o_rd_key;
    logic         o_rd_err;

    modport slave (
        input  i_key_load,
        input  i_key,
        input  i_next_rnd_key,
        input  i_rd_round,
        output o_busy,
        output o_done,
        output o_keys_valid,
        output o_pre_rnd_key,
        output o_en_key_gen,
        output o_round_num,
        output o_rd_key,
        output o_rd_err
    );

    modport master (
        output i_key_load,
        output i_key,
        output i_next_rnd_key,
        output i_rd_round,
        input  o_busy,
        input  o_done,
        input  o_keys_valid,
        input  o_pre_rnd_key,
        input  o_en_key_gen,
        input  o_round_num,
        input  o_rd_key,
        input  o_rd_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: sequences an external round-key generator and stores
// the full schedule in a registered-read key store.
module aes_key_sched_ctrl #(
    parameter int KEY_GEN_LAT = 1,
    parameter int NUM_ROUNDS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_sched_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [1:0] LAT_LAST = 2'(KEY_GEN_LAT - 1);

    state_t       r_state;
    state_t       w_next_state;

    logic [127:0] r_key_store [0:NUM_ROUNDS];
    logic [3:0]   r_round_cnt;
    logic [1:0]   r_wait_cnt;
    logic         r_done;
    logic         r_keys_valid;
    logic [127:0] r_pre_rnd_key;
    logic [3:0]   r_round_num;
    logic [127:0] r_rd_key;
    logic         r_rd_err;

    logic         w_gen_last;
    logic         w_more_rounds;
    logic         w_busy;
    logic         w_en_key_gen;
    logic         w_rd_oob;

    always_comb begin
        w_next_state  = r_state;
        w_busy        = 1'b0;
        w_en_key_gen  = 1'b0;
        w_gen_last    = (r_state == WAIT) && (r_wait_cnt == LAT_LAST);
        w_more_rounds = (r_round_cnt < LAST_RND);
        case (r_state)
            IDLE: begin
                w_next_state = IDLE;
            end
            ISSUE: begin
                w_busy       = 1'b1;
                w_en_key_gen = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                w_busy = 1'b1;
                if (w_gen_last) begin
                    w_next_state = w_more_rounds ? ISSUE : DONE;
                end
            end
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // A load in any state restarts the expansion on the same edge.
        if (bus.i_key_load) begin
            w_next_state = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The key handed to the generator is always the one written to the store on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round_cnt   <= 4'd0;
            r_round_num   <= 4'd0;
            r_pre_rnd_key <= '0;
            r_keys_valid  <= 1'b0;
            r_done        <= 1'b0;
            r_wait_cnt    <= 2'd0;
        end else begin
            r_done     <= 1'b0;
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
            if (bus.i_key_load) begin
                r_round_cnt   <= 4'd1;
                r_round_num   <= 4'd1;
                r_pre_rnd_key <= bus.i_key;
                r_keys_valid  <= 1'b0;
            end else if (w_gen_last) begin
                if (w_more_rounds) begin
                    r_round_cnt   <= r_round_cnt + 4'd1;
                    r_round_num   <= r_round_cnt + 4'd1;
                    r_pre_rnd_key <= bus.i_next_rnd_key;
                end else begin
                    r_keys_valid <= 1'b1;
                    r_done       <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_key_load) begin
            r_key_store[0] <= bus.i_key;
        end else if (w_gen_last) begin
            r_key_store[r_round_cnt] <= bus.i_next_rnd_key;
        end
    end

    assign w_rd_oob = (bus.i_rd_round > LAST_RND);

    // Registered read samples the store before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key <= '0;
            r_rd_err <= 1'b0;
        end else begin
            r_rd_err <= w_rd_oob;
            if (r_keys_valid && !w_rd_oob) begin
                r_rd_key <= r_key_store[bus.i_rd_round];
            end else begin
                r_rd_key <= '0;
            end
        end
    end

    assign bus.o_busy        = w_busy;
    assign bus.o_done        = r_done;
    assign bus.o_keys_valid  = r_keys_valid;
    assign bus.o_pre_rnd_key = r_pre_rnd_key;
    assign bus.o_en_key_gen  = w_en_key_gen;
    assign bus.o_round_num   = r_round_num;
    assign bus.o_rd_key      = r_rd_key;
    assign bus.o_rd_err      = r_rd_err;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: two builds (generator latency 1 and 3) each paired with a
// behavioural AES-128 round-key generator; reads are scoreboarded through a queue.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_key_sched_ctrl_if bus1 ();
    aes_key_sched_ctrl_if bus3 ();

    aes_key_sched_ctrl #(.KEY_GEN_LAT(1), .NUM_ROUNDS(10)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    aes_key_sched_ctrl #(.KEY_GEN_LAT(3), .NUM_ROUNDS(10)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] expKeyQ [$];
    logic         expErrQ [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] prev, input int rnd);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = prev;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] keyAt(input logic [127:0] key, input int rnd);
        logic [127:0] k;
        k = key;
        for (int r = 1; r <= rnd; r++) k = nextKey(k, r);
        return k;
    endfunction

    // Round-key generators: result valid KEY_GEN_LAT cycles after the enable cycle.
    logic [127:0] gen1;
    logic [127:0] gen3a, gen3b, gen3c;

    always @(posedge clk) begin
        if (bus1.o_en_key_gen) gen1 <= nextKey(bus1.o_pre_rnd_key, int'(bus1.o_round_num));
        if (bus3.o_en_key_gen) gen3a <= nextKey(bus3.o_pre_rnd_key, int'(bus3.o_round_num));
        gen3b <= gen3a;
        gen3c <= gen3b;
    end

    assign bus1.i_next_rnd_key = gen1;
    assign bus3.i_next_rnd_key = gen3c;

    logic       monArm;
    int         enCount, busyCount, doneCount;
    logic       seqBad;
    logic [3:0] lastRound;

    always @(negedge clk) begin
        if (!monArm) begin
            enCount   = 0;
            busyCount = 0;
            doneCount = 0;
            seqBad    = 1'b0;
            lastRound = 4'd0;
        end else begin
            if (bus1.o_en_key_gen) begin
                if (bus1.o_round_num != 4'(lastRound + 4'd1)) seqBad = 1'b1;
                lastRound = bus1.o_round_num;
                enCount++;
            end
            if (bus1.o_busy) busyCount++;
            if (bus1.o_done) doneCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [127:0] key);
        if (sel == 1) begin
            bus3.i_key      = key;
            bus3.i_key_load = 1'b1;
        end else begin
            bus1.i_key      = key;
            bus1.i_key_load = 1'b1;
        end
        @(posedge clk);
        #1;
        bus1.i_key_load = 1'b0;
        bus3.i_key_load = 1'b0;
    endtask

    task automatic waitDone(input int sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 1) ? bus3.o_done : bus1.o_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic doRead(input int sel, input int rnd, input logic [127:0] expKey,
                          input logic expErr, input string tag);
        logic [127:0] k;
        logic         e;
        if (sel == 1) bus3.i_rd_round = 4'(rnd);
        else          bus1.i_rd_round = 4'(rnd);
        expKeyQ.push_back(expKey);
        expErrQ.push_back(expErr);
        @(posedge clk);
        #1;
        k = expKeyQ.pop_front();
        e = expErrQ.pop_front();
        checkOutput({tag, "_key"}, (sel == 1) ? bus3.o_rd_key : bus1.o_rd_key, k);
        checkOutput({tag, "_err"}, 128'((sel == 1) ? bus3.o_rd_err : bus1.o_rd_err), 128'(e));
    endtask

    initial begin
        int  lat;
        bit  found;
        rst_n           = 1'b0;
        monArm          = 1'b0;
        bus1.i_key_load = 1'b0;
        bus1.i_key      = '0;
        bus1.i_rd_round = 4'd0;
        bus3.i_key_load = 1'b0;
        bus3.i_key      = '0;
        bus3.i_rd_round = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",    128'(bus1.o_busy),       '0);
        checkOutput("rst_done",    128'(bus1.o_done),       '0);
        checkOutput("rst_valid",   128'(bus1.o_keys_valid), '0);
        checkOutput("rst_en",      128'(bus1.o_en_key_gen), '0);
        checkOutput("rst_round",   128'(bus1.o_round_num),  '0);
        checkOutput("rst_pre",     bus1.o_pre_rnd_key,      '0);
        checkOutput("rst_rd_key",  bus1.o_rd_key,           '0);
        checkOutput("rst_rd_err",  128'(bus1.o_rd_err),     '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        doRead(0, 0, '0, 1'b0, "preload_r0");
        doRead(0, 11, '0, 1'b1, "preload_r11");

        $display("[TB] full expansion of key A");
        monArm = 1'b1;
        applyStimulus(0, KEY_A);
        checkOutput("load_valid_clr", 128'(bus1.o_keys_valid), '0);
        checkOutput("load_busy",      128'(bus1.o_busy),       128'(1));
        waitDone(0, lat);
        checkOutput("lat_a",       128'(lat),               128'(20));
        checkOutput("en_count",    128'(enCount),           128'(10));
        checkOutput("busy_cycles", 128'(busyCount),         128'(20));
        checkOutput("round_seq",   128'(seqBad),            '0);
        checkOutput("last_round",  128'(bus1.o_round_num),  128'(10));
        checkOutput("done_valid",  128'(bus1.o_keys_valid), 128'(1));
        checkOutput("done_busy",   128'(bus1.o_busy),       '0);
        checkOutput("pre_hold",    bus1.o_pre_rnd_key,      keyAt(KEY_A, 9));
        @(posedge clk);
        #1;
        checkOutput("done_pulse",  128'(bus1.o_done),       '0);
        checkOutput("done_count",  128'(doneCount),         128'(1));
        checkOutput("valid_hold",  128'(bus1.o_keys_valid), 128'(1));
        doRead(0, 0,  KEY_A,           1'b0, "a_r0");
        doRead(0, 1,  KEY_A_R1,        1'b0, "a_r1");
        doRead(0, 2,  keyAt(KEY_A, 2), 1'b0, "a_r2");
        doRead(0, 10, KEY_A_R10,       1'b0, "a_r10");
        doRead(0, 11, '0,              1'b1, "a_r11");
        doRead(0, 15, '0,              1'b1, "a_r15");

        $display("[TB] abort run with reload of key B");
        monArm = 1'b0;
        @(posedge clk);
        #1;
        monArm = 1'b1;
        applyStimulus(0, KEY_A);
        repeat (5) @(posedge clk);
        #1;
        doRead(0, 1, '0, 1'b0, "busy_r1");
        applyStimulus(0, KEY_B);
        checkOutput("reload_round", 128'(bus1.o_round_num), 128'(1));
        checkOutput("reload_pre",   bus1.o_pre_rnd_key,     KEY_B);
        waitDone(0, lat);
        checkOutput("lat_b", 128'(lat), 128'(20));
        @(posedge clk);
        #1;
        checkOutput("abort_done_count", 128'(doneCount), 128'(1));
        doRead(0, 10, KEY_B_R10, 1'b0, "b_r10");
        doRead(0, 0,  KEY_B,     1'b0, "b_r0");

        $display("[TB] same-edge read and reset during round 5");
        bus1.i_rd_round = 4'd0;
        expKeyQ.push_back(KEY_B);
        applyStimulus(0, KEY_A);
        checkOutput("old_content", bus1.o_rd_key, expKeyQ.pop_front());
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (bus1.o_round_num == 4'd5 && bus1.o_busy && !bus1.o_en_key_gen) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("found_wait5", 128'(found), 128'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy",   128'(bus1.o_busy),       '0);
        checkOutput("mid_valid",  128'(bus1.o_keys_valid), '0);
        checkOutput("mid_en",     128'(bus1.o_en_key_gen), '0);
        checkOutput("mid_round",  128'(bus1.o_round_num),  '0);
        checkOutput("mid_pre",    bus1.o_pre_rnd_key,      '0);
        checkOutput("mid_done",   128'(bus1.o_done),       '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_valid", 128'(bus1.o_keys_valid), '0);
        checkOutput("post_rst_busy",  128'(bus1.o_busy),       '0);
        doRead(0, 1, '0, 1'b0, "post_rst_r1");
        applyStimulus(0, KEY_A);
        waitDone(0, lat);
        checkOutput("lat_after_rst", 128'(lat), 128'(20));
        @(posedge clk);
        #1;
        doRead(0, 10, KEY_A_R10, 1'b0, "rst_a_r10");

        $display("[TB] generator latency 3 build");
        applyStimulus(1, KEY_A);
        waitDone(1, lat);
        checkOutput("lat3", 128'(lat), 128'(40));
        doRead(1, 0,  KEY_A,     1'b0, "l3_r0");
        doRead(1, 1,  KEY_A_R1,  1'b0, "l3_r1");
        doRead(1, 10, KEY_A_R10, 1'b0, "l3_r10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter KEY_GEN_LAT, default 1, meaning the number of cycles from o_en_key_gen high to a valid i_next_rnd_key (range 1..4).
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, meaning the index of the last round key (AES-128).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_key_load  in  1  single-cycle request to start expansion of i_key.
REQ-006 i_key  in  128  cipher key, sampled on the edge where i_key_load=1.
REQ-007 o_busy  out  1  expansion in progress.
REQ-008 o_done  out  1  one-cycle pulse when all round keys are stored.
REQ-009 o_keys_valid  out  1  key store holds a complete, consistent schedule.
REQ-010 o_pre_rnd_key  out  128  previous round key, driven to the key generator.
REQ-011 o_en_key_gen  out  1  key-generator enable.
REQ-012 o_round_num  out  4  round index of the key being generated.
REQ-013 i_next_rnd_key  in  128  key-generator result.
REQ-014 i_rd_round  in  4  read index into the key store.
REQ-015 o_rd_key  out  128  registered read data.
REQ-016 o_rd_err  out  1  registered flag: read index > NUM_ROUNDS.

Function
REQ-017 SHALL contain an 11 x 128-bit key store, entry r = round key r, and a 4-bit round counter.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE/DONE + i_key_load: write i_key to entry 0, set round counter to 1, clear o_keys_valid, go to ISSUE.
REQ-020 ISSUE (exactly one cycle): o_en_key_gen=1, o_round_num=counter, o_pre_rnd_key=entry[counter-1]; next state WAIT.
REQ-021 WAIT: count KEY_GEN_LAT cycles; on the edge ending the last of them, write i_next_rnd_key to entry[counter].
REQ-022 WAIT exit: if counter<NUM_ROUNDS, increment the counter and go to ISSUE; otherwise go to DONE.
REQ-023 DONE entry edge: o_keys_valid set, o_done high for exactly the first DONE cycle; DONE holds until the next load.
REQ-024 o_en_key_gen SHALL be 0 in every state except ISSUE; o_pre_rnd_key and o_round_num hold their last values outside ISSUE.
REQ-025 Load-to-done latency: o_done SHALL assert NUM_ROUNDS*(KEY_GEN_LAT+1) cycles after the load edge (20 cycles at the defaults).
REQ-026 o_busy SHALL be 1 in ISSUE and WAIT, and 0 in IDLE and DONE.
REQ-027 i_key_load in ISSUE or WAIT SHALL abort the current expansion and restart it per REQ-019 on the same edge; o_done is not pulsed for the aborted run.
REQ-028 A key-generator result still in flight after an abort SHALL be discarded (WAIT counter restarts; entry 0 is rewritten).
REQ-029 Read: o_rd_key <= entry[i_rd_round] one cycle after the request when o_keys_valid=1 and i_rd_round<=NUM_ROUNDS; otherwise 0.
REQ-030 o_rd_err <= 1 iff i_rd_round>NUM_ROUNDS, regardless of o_keys_valid.
REQ-031 A read in the same cycle as a store write SHALL return the old entry content.
REQ-032 The round counter SHALL never exceed NUM_ROUNDS and SHALL never wrap.

Reset
REQ-033 While rst_n=0: FSM=IDLE, counter=0, o_busy=0, o_done=0, o_keys_valid=0, o_en_key_gen=0, o_round_num=0, o_pre_rnd_key=0, o_rd_key=0, o_rd_err=0.
REQ-034 Key-store contents are don't-care after reset; they are unreadable until o_keys_valid=1.
REQ-035 Reset asserted mid-expansion SHALL return the block to IDLE immediately; the first cycle after rst_n rises behaves as IDLE.

Verification
REQ-036 Bench pairs the block with the team's aes_key_gen.
- Load 2b7e151628aed2a6abf7158809cf4f3c -> o_done exactly 20 cycles later; the read of round 1 returns a0fafe1788542cb123a339392a6c7605; the read of round 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- During the run -> o_en_key_gen high 10 times, o_round_num sequence 1..10, o_busy high for 20 cycles.
- Reload at cycle 7 of a run with key 000102030405060708090a0b0c0d0e0f -> no o_done for the first key; o_done 20 cycles after the reload; round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- i_rd_round=11 and =15 -> o_rd_key=0, o_rd_err=1; reads before the first o_done -> o_rd_key=0.
- rst_n pulsed low during WAIT of round 5 -> all outputs at reset values; o_keys_valid stays 0 until a new load completes.
- KEY_GEN_LAT=3 build -> o_done 40 cycles after the load edge; round keys identical to the default build.
